// File: rtl/usr_shift_ctrl_pkg.sv
// Shared encodings and defaults for the universal shift-register command sequencer.
package usr_shift_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  // Datapath mux select, also used by the register itself
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHR  = 2'b10,
    OP_SHL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Command fields held for the duration of one command
  typedef struct packed {
    op_e  op;
    logic rot;
    logic fill;
  } cmd_lat_t;

endpackage

// File: rtl/usr_shift_cnt.sv
// Loadable down-counter for shift cycles; last_c flags the final active cycle.
module usr_shift_cnt
  import usr_shift_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for the universal shift register: accepts one command at a
// time and drives mode, parallel data and serial-fill bits to the datapath.
module usr_shift_ctrl
  import usr_shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_r,
  output logic             ser_l,
  output logic             busy,
  output logic             done
);

  state_e   state_q;
  state_e   state_d;
  cmd_lat_t lat_q;
  op_e      cmd_op_e;
  logic     accept;
  logic     cnt_last_c;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = cmd_valid && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_e)
            OP_LOAD:        state_d = ST_LOAD;
            OP_SHR, OP_SHL: state_d = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_last_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    mode      = MODE_HOLD;
    busy      = 1'b1;
    done      = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
      end
      ST_LOAD:  mode = MODE_LOAD;
      ST_SHIFT: mode = (lat_q.op == OP_SHL) ? MODE_SHL : MODE_SHR;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Command latch; par_out only changes when a LOAD is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_q   <= '0;
      par_out <= '0;
    end else if (accept) begin
      lat_q <= '{op: cmd_op_e, rot: cmd_rot, fill: cmd_fill};
      if (cmd_op_e == OP_LOAD) begin
        par_out <= cmd_data;
      end
    end
  end

  usr_shift_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cmd_count),
    .dec      (state_q == ST_SHIFT),
    .last_c   (cnt_last_c)
  );

  // Rotate feeds back the bit leaving the opposite end
  assign ser_r = lat_q.rot ? q[0]       : lat_q.fill;
  assign ser_l = lat_q.rot ? q[WIDTH-1] : lat_q.fill;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl with a behavioural 8-bit universal register.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_rot;
  logic       cmd_fill;
  logic [3:0] cmd_count;
  logic [7:0] cmd_data;
  logic [7:0] q;
  logic [1:0] mode;
  logic [7:0] par_out;
  logic       ser_r;
  logic       ser_l;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  usr_shift_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rot   (cmd_rot),
    .cmd_fill  (cmd_fill),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .q         (q),
    .mode      (mode),
    .par_out   (par_out),
    .ser_r     (ser_r),
    .ser_l     (ser_l),
    .busy      (busy),
    .done      (done)
  );

  // Universal register: keeps its contents through controller reset
  initial q = 8'h00;
  always @(posedge clk) begin
    case (mode)
      2'b01:   q <= {ser_r, q[7:1]};
      2'b10:   q <= {q[6:0], ser_l};
      2'b11:   q <= par_out;
      default: q <= q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (accept edge t); returns in cycle t+1
  task automatic issue(input logic [1:0] op, input logic rot, input logic fill,
                       input logic [3:0] cnt, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rot   = rot;
    cmd_fill  = fill;
    cmd_count = cnt;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rot   = 1'b0;
    cmd_fill  = 1'b0;
    cmd_count = 4'd0;
    cmd_data  = 8'h00;

    // 1: reset
    tick();
    tick();
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_par", 32'(par_out), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'h1);

    // 2: LOAD A5
    issue(2'b01, 1'b0, 1'b0, 4'd0, 8'hA5);
    chk("ld_mode", 32'(mode), 32'h3);
    chk("ld_par", 32'(par_out), 32'hA5);
    chk("ld_busy", 32'(busy), 32'h1);
    chk("ld_ready", 32'(cmd_ready), 32'h0);
    chk("ld_nodone", 32'(done), 32'h0);
    tick();
    chk("ld_done", 32'(done), 32'h1);
    chk("ld_mode_hold", 32'(mode), 32'h0);
    chk("ld_q", 32'(q), 32'hA5);
    tick();
    chk("ld_idle_ready", 32'(cmd_ready), 32'h1);
    chk("ld_done_pulse", 32'(done), 32'h0);

    // 3: SHIFT_L x3 fill 1 from A5; LOAD FF pulsed while busy must be ignored
    issue(2'b11, 1'b0, 1'b1, 4'd3, 8'h00);
    chk("shl_ser_l", 32'(ser_l), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("shl_mode", 32'(mode), 32'h2);
      chk("shl_done_lo", 32'(done), 32'h0);
      if (i == 1) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'hFF;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("shl_done", 32'(done), 32'h1);
    chk("shl_q", 32'(q), 32'h2F);
    tick();
    chk("shl_par_kept", 32'(par_out), 32'hA5);

    // 4: LOAD 81 then rotate right by 10
    issue(2'b01, 1'b0, 1'b0, 4'd0, 8'h81);
    tick();
    tick();
    issue(2'b10, 1'b1, 1'b0, 4'd10, 8'h00);
    chk("ror_ser_r", 32'(ser_r), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk("ror_mode", 32'(mode), 32'h1);
      tick();
    end
    chk("ror_done", 32'(done), 32'h1);
    chk("ror_q", 32'(q), 32'h60);
    tick();

    // 5: NOP, valid pulse during DONE, then SHIFT_R count 0
    issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("nop_done", 32'(done), 32'h1);
    chk("nop_mode", 32'(mode), 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'h33;
    tick();
    cmd_valid = 1'b0;
    chk("nop_ignored_busy", 32'(busy), 32'h0);
    chk("nop_ignored_mode", 32'(mode), 32'h0);
    tick();
    chk("nop_ignored_q", 32'(q), 32'h60);
    issue(2'b10, 1'b0, 1'b1, 4'd0, 8'h00);
    chk("z_done", 32'(done), 32'h1);
    chk("z_mode", 32'(mode), 32'h0);
    tick();
    chk("z_q", 32'(q), 32'h60);
    chk("z_ready", 32'(cmd_ready), 32'h1);

    // 6: LOAD 01, SHIFT_L x5, reset during the 2nd shift cycle
    issue(2'b01, 1'b0, 1'b0, 4'd0, 8'h01);
    tick();
    tick();
    issue(2'b11, 1'b0, 1'b0, 4'd5, 8'h00);
    chk("ab_mode1", 32'(mode), 32'h2);
    tick();
    chk("ab_mode2", 32'(mode), 32'h2);
    rst_n = 1'b0;
    tick();
    chk("ab_mode_hold", 32'(mode), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_nodone", 32'(done), 32'h0);
    chk("ab_q", 32'(q), 32'h04);
    rst_n = 1'b1;
    tick();
    chk("ab_ready", 32'(cmd_ready), 32'h1);
    chk("ab_nodone2", 32'(done), 32'h0);
    chk("ab_q2", 32'(q), 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
